// File: rtl/reg_bank_wr_pkg.sv
// Shared constants for the byte/word write register bank: width-mode
// encodings, byte-lane indices and the fixed two-byte register geometry.
package reg_bank_wr_pkg;

    // Width-mode encodings carried on the w input
    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_WORD = 1'b1;

    // Byte-lane indices inside one register
    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

    // Register geometry: this generation is fixed at two bytes per register
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int DW_FIXED       = BYTE_W * BYTES_PER_WORD;

    // Position of a register's byte lane in the flat lane-enable vector
    function automatic int lane_idx(input int reg_i, input int lane);
        return (reg_i * BYTES_PER_WORD) + lane;
    endfunction

endpackage

// File: rtl/wr_lane_deco.sv
// Combinational write-lane decoder: turns a write request, width mode and
// target select into a 2*NREG byte-lane enable vector. Word writes hit both
// lanes of reg sel; byte writes address a flat byte space where the lower
// half of sel values maps to low lanes and the upper half to high lanes.
module wr_lane_deco
    import reg_bank_wr_pkg::*;
#(
    parameter int NREG = 8
) (
    input  logic                      wr,
    input  logic                      w,
    input  logic [$clog2(NREG)-1:0]   sel,
    output logic [2*NREG-1:0]         lane_en
);

    localparam int SW   = $clog2(NREG);
    localparam int HALF = NREG / 2;

    logic word_s;
    logic byte_s;

    assign word_s = wr & (w == MODE_WORD);
    assign byte_s = wr & (w == MODE_BYTE);

    for (genvar g = 0; g < NREG; g++) begin : g_lane
        localparam int LO = lane_idx(g, LANE_LO);
        localparam int HI = lane_idx(g, LANE_HI);

        logic hit_s;
        assign hit_s = (sel == SW'(g));

        if (g < HALF) begin : g_lower
            // Lower-half registers also own the byte-mode low/high aliases
            logic alias_s;
            assign alias_s     = (sel == SW'(g + HALF));
            assign lane_en[LO] = (word_s | byte_s) & hit_s;
            assign lane_en[HI] = (word_s & hit_s) | (byte_s & alias_s);
        end else begin : g_upper
            // Upper-half registers are reachable only with word writes
            assign lane_en[LO] = word_s & hit_s;
            assign lane_en[HI] = word_s & hit_s;
        end
    end

endmodule

// File: rtl/reg_bank_wr.sv
// Byte/word write register bank. A write is accepted every cycle, decoded to
// byte-lane enables, and held one cycle in a stage register (enables plus
// lane-aligned data) before it commits into the bank. Two combinational
// word read ports see the bank with per-lane forwarding from the stage, so
// a read always returns the most recent accepted write for each lane.
module reg_bank_wr
    import reg_bank_wr_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic                      w,
    input  logic [$clog2(NREG)-1:0]   sel,
    input  logic [DW-1:0]             wdata,
    input  logic [$clog2(NREG)-1:0]   rsel_a,
    input  logic [$clog2(NREG)-1:0]   rsel_b,
    output logic [2*NREG-1:0]         we,
    output logic                      ack,
    output logic [DW-1:0]             rdata_a,
    output logic [DW-1:0]             rdata_b
);

    // Elaboration-time parameter checks
    if (DW != DW_FIXED) begin : g_bad_dw
        $error("reg_bank_wr: DW must be 16 in this generation");
    end
    if ((NREG < 2) || ((NREG % 2) != 0)) begin : g_bad_nreg
        $error("reg_bank_wr: NREG must be even and at least 2");
    end

    logic [2*NREG-1:0] lane_en_s;
    logic [DW-1:0]     wr_data_s;
    logic [2*NREG-1:0] stg_we_r;
    logic [DW-1:0]     stg_data_r;
    logic              ack_r;
    logic [DW-1:0]     fwd_s [NREG];

    wr_lane_deco #(
        .NREG (NREG)
    ) u_deco (
        .wr      (wr),
        .w       (w),
        .sel     (sel),
        .lane_en (lane_en_s)
    );

    // Align write data: a byte is replicated onto both lanes so the stage
    // carries it on whichever lane the decoder enabled
    always_comb begin
        wr_data_s = {DW{1'b0}};
        if (w == MODE_WORD) begin
            wr_data_s = wdata;
        end else begin
            wr_data_s = {BYTES_PER_WORD{wdata[BYTE_W-1:0]}};
        end
    end

    // Stage register: holds the decoded write for its commit cycle; reset
    // clears it so neither an incoming nor a pending write survives
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_we_r   <= {(2*NREG){1'b0}};
            stg_data_r <= {DW{1'b0}};
            ack_r      <= 1'b0;
        end else begin
            stg_we_r   <= lane_en_s;
            stg_data_r <= wr_data_s;
            ack_r      <= |lane_en_s;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam int LO = lane_idx(g, LANE_LO);
        localparam int HI = lane_idx(g, LANE_HI);

        logic [DW-1:0] row_r;

        // Bank row: each lane commits independently from the stage register
        always_ff @(posedge clk) begin
            if (rst) begin
                row_r <= {DW{1'b0}};
            end else begin
                if (stg_we_r[LO]) begin
                    row_r[LANE_LO*BYTE_W +: BYTE_W] <= stg_data_r[LANE_LO*BYTE_W +: BYTE_W];
                end
                if (stg_we_r[HI]) begin
                    row_r[LANE_HI*BYTE_W +: BYTE_W] <= stg_data_r[LANE_HI*BYTE_W +: BYTE_W];
                end
            end
        end

        // Forwarded view of the row: a lane pending commit shows its new byte
        assign fwd_s[g][LANE_LO*BYTE_W +: BYTE_W] = stg_we_r[LO] ?
            stg_data_r[LANE_LO*BYTE_W +: BYTE_W] : row_r[LANE_LO*BYTE_W +: BYTE_W];
        assign fwd_s[g][LANE_HI*BYTE_W +: BYTE_W] = stg_we_r[HI] ?
            stg_data_r[LANE_HI*BYTE_W +: BYTE_W] : row_r[LANE_HI*BYTE_W +: BYTE_W];
    end

    assign we      = stg_we_r;
    assign ack     = ack_r;
    assign rdata_a = fwd_s[rsel_a];
    assign rdata_b = fwd_s[rsel_b];

endmodule

// File: tb/tb_reg_bank_wr.sv
// Directed and randomized self-checking bench for reg_bank_wr (NREG=8, DW=16).
`timescale 1ns/1ps
module tb_reg_bank_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        w;
    logic [2:0]  sel;
    logic [15:0] wdata;
    logic [2:0]  rsel_a;
    logic [2:0]  rsel_b;
    logic [15:0] we;
    logic        ack;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;

    int n_cmp = 0;
    int n_err = 0;

    reg_bank_wr #(.NREG(8), .DW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .w       (w),
        .sel     (sel),
        .wdata   (wdata),
        .rsel_a  (rsel_a),
        .rsel_b  (rsel_b),
        .we      (we),
        .ack     (ack),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v_wr, input logic v_w, input logic [2:0] v_sel,
                         input logic [15:0] v_data);
        wr = v_wr; w = v_w; sel = v_sel; wdata = v_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; rsel_a = 3'd0; rsel_b = 3'd0;
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++; if (we !== 16'h0000) begin n_err++; $display("FAIL reset_we: got %h expected %h", we, 16'h0000); end
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected %b", ack, 1'b0); end
        for (int i = 0; i < 8; i++) begin
            rsel_a = 3'(i); rsel_b = 3'(7 - i); #1;
            n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL reset_rd_a[%0d]: got %h expected %h", i, rdata_a, 16'h0000); end
            n_cmp++; if (rdata_b !== 16'h0000) begin n_err++; $display("FAIL reset_rd_b[%0d]: got %h expected %h", i, rdata_b, 16'h0000); end
        end
    endtask

    task automatic test_word_write();
        drive(1'b1, 1'b1, 3'd0, 16'h1234);
        cyc();
        n_cmp++; if (we !== 16'h0003) begin n_err++; $display("FAIL word_we: got %h expected %h", we, 16'h0003); end
        n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL word_ack: got %b expected %b", ack, 1'b1); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        rsel_a = 3'd0; #1;
        n_cmp++; if (rdata_a !== 16'h1234) begin n_err++; $display("FAIL word_fwd: got %h expected %h", rdata_a, 16'h1234); end
        cyc();
        n_cmp++; if (we !== 16'h0000) begin n_err++; $display("FAIL word_we_idle: got %h expected %h", we, 16'h0000); end
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL word_ack_idle: got %b expected %b", ack, 1'b0); end
        n_cmp++; if (rdata_a !== 16'h1234) begin n_err++; $display("FAIL word_bank: got %h expected %h", rdata_a, 16'h1234); end
    endtask

    task automatic test_byte_write();
        drive(1'b1, 1'b0, 3'd4, 16'h00AB);
        cyc();
        n_cmp++; if (we !== 16'h0002) begin n_err++; $display("FAIL byte_hi_we: got %h expected %h", we, 16'h0002); end
        drive(1'b1, 1'b0, 3'd3, 16'h00CD);
        cyc();
        n_cmp++; if (we !== 16'h0040) begin n_err++; $display("FAIL byte_lo_we: got %h expected %h", we, 16'h0040); end
        rsel_a = 3'd0; #1;
        n_cmp++; if (rdata_a !== 16'hAB34) begin n_err++; $display("FAIL byte_hi_keep_lo: got %h expected %h", rdata_a, 16'hAB34); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        rsel_a = 3'd3; #1;
        n_cmp++; if (rdata_a !== 16'h00CD) begin n_err++; $display("FAIL byte_lo_reg3: got %h expected %h", rdata_a, 16'h00CD); end
        // Top byte-select value reaches the high lane of the last lower register
        drive(1'b1, 1'b0, 3'd7, 16'hFF5A);
        cyc();
        n_cmp++; if (we !== 16'h0080) begin n_err++; $display("FAIL byte_sel7_we: got %h expected %h", we, 16'h0080); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        n_cmp++; if (rdata_a !== 16'h5ACD) begin n_err++; $display("FAIL byte_sel7_rd: got %h expected %h", rdata_a, 16'h5ACD); end
        drive(1'b1, 1'b1, 3'd7, 16'h9876);
        cyc();
        n_cmp++; if (we !== 16'hC000) begin n_err++; $display("FAIL word_sel7_we: got %h expected %h", we, 16'hC000); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        rsel_a = 3'd7; rsel_b = 3'd7; #1;
        n_cmp++; if (rdata_a !== 16'h9876) begin n_err++; $display("FAIL word_sel7_rd: got %h expected %h", rdata_a, 16'h9876); end
        n_cmp++; if (rdata_b !== 16'h9876) begin n_err++; $display("FAIL same_sel_b: got %h expected %h", rdata_b, 16'h9876); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 3'd2, 16'h5555);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        rsel_a = 3'd2; rsel_b = 3'd2; #1;
        n_cmp++; if (rdata_a !== 16'h5555) begin n_err++; $display("FAIL fwd_a: got %h expected %h", rdata_a, 16'h5555); end
        n_cmp++; if (rdata_b !== 16'h5555) begin n_err++; $display("FAIL fwd_b: got %h expected %h", rdata_b, 16'h5555); end
        cyc();
        drive(1'b1, 1'b1, 3'd2, 16'h1111);
        cyc();
        n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack1: got %b expected %b", ack, 1'b1); end
        drive(1'b1, 1'b1, 3'd2, 16'h2222);
        cyc();
        n_cmp++; if (we !== 16'h0030) begin n_err++; $display("FAIL b2b_we2: got %h expected %h", we, 16'h0030); end
        n_cmp++; if (rdata_a !== 16'h2222) begin n_err++; $display("FAIL b2b_fwd: got %h expected %h", rdata_a, 16'h2222); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        n_cmp++; if (rdata_a !== 16'h2222) begin n_err++; $display("FAIL b2b_final: got %h expected %h", rdata_a, 16'h2222); end
        // Word then high-byte to the same register: per-lane forwarding
        drive(1'b1, 1'b1, 3'd2, 16'h1111);
        cyc();
        drive(1'b1, 1'b0, 3'd6, 16'h0077);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        #1;
        n_cmp++; if (rdata_a !== 16'h7711) begin n_err++; $display("FAIL lane_fwd: got %h expected %h", rdata_a, 16'h7711); end
        cyc();
        n_cmp++; if (rdata_a !== 16'h7711) begin n_err++; $display("FAIL lane_commit: got %h expected %h", rdata_a, 16'h7711); end
    endtask

    task automatic test_reset_drop();
        // Write pending in the stage when reset arrives
        drive(1'b1, 1'b1, 3'd5, 16'hBEEF);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_pend_ack: got %b expected %b", ack, 1'b0); end
        n_cmp++; if (we !== 16'h0000) begin n_err++; $display("FAIL rst_pend_we: got %h expected %h", we, 16'h0000); end
        rsel_a = 3'd5; #1;
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL rst_pend_reg5: got %h expected %h", rdata_a, 16'h0000); end
        // Write presented together with reset is dropped
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'd6, 16'hABCD);
        cyc();
        rst = 1'b0;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_same_ack: got %b expected %b", ack, 1'b0); end
        rsel_a = 3'd6; #1;
        n_cmp++; if (rdata_a !== 16'h0000) begin n_err++; $display("FAIL rst_same_reg6: got %h expected %h", rdata_a, 16'h0000); end
        // First write after reset deasserts behaves normally
        drive(1'b1, 1'b1, 3'd6, 16'hCAFE);
        cyc();
        n_cmp++; if (we !== 16'h3000) begin n_err++; $display("FAIL post_rst_we: got %h expected %h", we, 16'h3000); end
        n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL post_rst_ack: got %b expected %b", ack, 1'b1); end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        n_cmp++; if (rdata_a !== 16'hCAFE) begin n_err++; $display("FAIL post_rst_rd: got %h expected %h", rdata_a, 16'hCAFE); end
    endtask

    task automatic test_random();
        logic [15:0] m_vis [8];
        logic [15:0] ew;
        logic [15:0] d;
        int          s;
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) m_vis[r] = 16'h0000;
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom));
            s  = int'(sel);
            ew = 16'h0000;
            if (wr) begin
                if (w) begin
                    ew[2*s] = 1'b1; ew[2*s+1] = 1'b1;
                end else if (s < 4) begin
                    ew[2*s] = 1'b1;
                end else begin
                    ew[2*(s-4)+1] = 1'b1;
                end
            end
            d = w ? wdata : {wdata[7:0], wdata[7:0]};
            cyc();
            n_cmp++; if (we !== ew) begin n_err++; $display("FAIL rnd_we[%0d]: got %h expected %h", k, we, ew); end
            n_cmp++; if (ack !== (ew != 16'h0000)) begin n_err++; $display("FAIL rnd_ack[%0d]: got %b expected %b", k, ack, (ew != 16'h0000)); end
            for (int r = 0; r < 8; r++) begin
                if (ew[2*r])   m_vis[r][7:0]  = d[7:0];
                if (ew[2*r+1]) m_vis[r][15:8] = d[15:8];
            end
            rsel_a = 3'($urandom_range(0, 7));
            rsel_b = 3'($urandom_range(0, 7));
            #1;
            n_cmp++; if (rdata_a !== m_vis[rsel_a]) begin n_err++; $display("FAIL rnd_rd_a[%0d] reg%0d: got %h expected %h", k, rsel_a, rdata_a, m_vis[rsel_a]); end
            n_cmp++; if (rdata_b !== m_vis[rsel_b]) begin n_err++; $display("FAIL rnd_rd_b[%0d] reg%0d: got %h expected %h", k, rsel_b, rdata_b, m_vis[rsel_b]); end
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000);
        cyc(); cyc();
        for (int r = 0; r < 8; r++) begin
            rsel_a = 3'(r); #1;
            n_cmp++; if (rdata_a !== m_vis[r]) begin n_err++; $display("FAIL rnd_sweep reg%0d: got %h expected %h", r, rdata_a, m_vis[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_write();
        test_back_to_back();
        test_reset_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
